// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths, types and constants
package rf_pkg;
  localparam int RF_ADDR_W = 4;
  localparam int RF_DATA_W = 16;
  localparam int RF_NREGS = 16;
  localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = 4'h0;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational priority picker starting the search at a rotating index
// Ports: req (request vector), start (first index searched, wraps),
//        gnt (one-hot grant, 0 when no request), idx (encoded winner, 0 when none)
module rr_pick #(
  parameter int N = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  int i;
  // Walk from the farthest candidate back to start so the closest one to start wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    i = 0;
    for (int k = N - 1; k >= 0; k--) begin
      i = int'(start) + k;
      i = (i >= N) ? i - N : i;
      if (req[i]) begin
        gnt = '0;
        gnt[i] = 1'b1;
        idx = IW'(i);
      end
    end
  end
endmodule

// File: rtl/rf_wb_arb.sv
// rf_wb_arb: write-back arbiter sharing the register file's single write port
// Ports: clk, rst (async, active-high); req_vld/req_addr/req_data per requester (packed);
//        req_rdy (combinational one-hot grant); hold (freezes arbiter, masks we);
//        we/dst_addr/dst (registered write port); pend (one-hot of dst_addr while we).
// Build option: RF_WB_RR_EN selects round-robin priority; otherwise fixed
// lowest-index priority and no last-grant register.
module rf_wb_arb
  import rf_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_vld,
  input  logic [NREQ*RF_ADDR_W-1:0] req_addr,
  input  logic [NREQ*RF_DATA_W-1:0] req_data,
  output logic [NREQ-1:0]          req_rdy,
  input  logic                     hold,
  output logic                     we,
  output rf_addr_t                 dst_addr,
  output rf_data_t                 dst,
  output logic [RF_NREGS-1:0]      pend
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] start;
  logic [IW-1:0] win;
  logic [NREQ-1:0] gnt;
  logic xfer;
  logic we_q;
  rf_addr_t win_addr;
  rf_data_t win_data;
`ifdef RF_WB_RR_EN
  logic [IW-1:0] last;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last <= IW'(NREQ - 1);
    else if (xfer) last <= win;
  end
  assign start = (last == IW'(NREQ - 1)) ? '0 : last + 1'b1;
`else
  assign start = '0;
`endif
  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req  (req_vld),
    .start(start),
    .gnt  (gnt),
    .idx  (win)
  );
  assign req_rdy = hold ? '0 : gnt;
  assign xfer = |req_rdy;
  assign win_addr = req_addr[RF_ADDR_W*int'(win) +: RF_ADDR_W];
  assign win_data = req_data[RF_DATA_W*int'(win) +: RF_DATA_W];
  // During hold we_q is frozen, so a latched write replays once hold drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q <= 1'b0;
      dst_addr <= '0;
      dst <= '0;
    end else if (!hold) begin
      we_q <= xfer && (win_addr != RF_ZERO_REG);
      if (xfer) begin
        dst_addr <= win_addr;
        dst <= win_data;
      end
    end
  end
  assign we = we_q & ~hold;
  assign pend = we ? (RF_NREGS'(1) << dst_addr) : '0;
endmodule

// File: tb/tb_rf_wb_arb.sv
// tb_rf_wb_arb: table, directed and random checks of rf_wb_arb against a behavioural model
module tb_rf_wb_arb;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_vld, req_rdy;
  logic [N*4-1:0] req_addr;
  logic [N*16-1:0] req_data;
  logic hold, we;
  logic [3:0] dst_addr;
  logic [15:0] dst, pend;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  rf_wb_arb #(.NREQ(N)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_addr(req_addr), .req_data(req_data),
    .req_rdy(req_rdy), .hold(hold), .we(we), .dst_addr(dst_addr), .dst(dst), .pend(pend)
  );
  logic [15:0] rf [16];
  always @(negedge clk) begin
    if (rst) for (int i = 0; i < 16; i++) rf[i] <= '0;
    else if (we) rf[dst_addr] <= dst;
  end
  int m_last;
  logic m_we;
  logic [3:0] m_a;
  logic [15:0] m_d;
  task automatic m_reset();
    m_last = N - 1;
    m_we = 1'b0;
    m_a = '0;
    m_d = '0;
  endtask
  function automatic int m_pick();
    if (hold) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
`ifdef RF_WB_RR_EN
      i = (m_last + 1 + k) % N;
`else
      i = k;
`endif
      if (req_vld[i]) return i;
    end
    return -1;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc();
    int g;
    logic [N-1:0] er;
    logic ew;
    #3;
    g = m_pick();
    er = (g >= 0) ? (N'(1) << g) : '0;
    ew = m_we & ~hold;
    check("rdy", req_rdy, er);
    check("we", we, ew);
    check("dst_addr", dst_addr, m_a);
    check("dst", dst, m_d);
    check("pend", pend, ew ? (16'h1 << m_a) : 16'h0);
    @(posedge clk);
    if (!hold) begin
      m_we = 1'b0;
      if (g >= 0) begin
        m_we = req_addr[4*g +: 4] != 4'h0;
        m_a = req_addr[4*g +: 4];
        m_d = req_data[16*g +: 16];
        m_last = g;
      end
    end
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_vld = '0;
    req_addr = '0;
    req_data = '0;
    hold = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  typedef struct {
    logic [2:0]  vld;
    logic        hld;
    logic [11:0] addr;
    logic [2:0]  rdy_rr;
    logic [2:0]  rdy_fx;
    logic        we;
  } vec_t;
  vec_t tbl [11];
  initial begin
    tbl[0]  = '{3'b111, 1'b0, 12'h321, 3'b001, 3'b001, 1'b0};
    tbl[1]  = '{3'b111, 1'b0, 12'h321, 3'b010, 3'b001, 1'b1};
    tbl[2]  = '{3'b111, 1'b0, 12'h321, 3'b100, 3'b001, 1'b1};
    tbl[3]  = '{3'b000, 1'b0, 12'h321, 3'b000, 3'b000, 1'b1};
    tbl[4]  = '{3'b010, 1'b0, 12'h301, 3'b010, 3'b010, 1'b0};
    tbl[5]  = '{3'b111, 1'b0, 12'h321, 3'b100, 3'b001, 1'b0};
    tbl[6]  = '{3'b111, 1'b1, 12'h321, 3'b000, 3'b000, 1'b0};
    tbl[7]  = '{3'b000, 1'b0, 12'h321, 3'b000, 3'b000, 1'b1};
    tbl[8]  = '{3'b111, 1'b0, 12'h321, 3'b001, 3'b001, 1'b0};
    tbl[9]  = '{3'b101, 1'b0, 12'h321, 3'b100, 3'b001, 1'b1};
    tbl[10] = '{3'b000, 1'b0, 12'h321, 3'b000, 3'b000, 1'b1};
    do_reset();
    check("reset_we", we, 1'b0);
    check("reset_dst_addr", dst_addr, 4'h0);
    check("reset_dst", dst, 16'h0);
    check("reset_pend", pend, 16'h0);
    for (int r = 0; r < 11; r++) begin
      logic [2:0] er;
`ifdef RF_WB_RR_EN
      er = tbl[r].rdy_rr;
`else
      er = tbl[r].rdy_fx;
`endif
      req_vld = tbl[r].vld;
      hold = tbl[r].hld;
      req_addr = tbl[r].addr;
      req_data = 48'h3333_2222_1111;
      #2;
      check($sformatf("tbl%0d_rdy", r), req_rdy, er);
      check($sformatf("tbl%0d_we", r), we, tbl[r].we);
      cyc();
    end
    do_reset();
    req_vld = 3'b001;
    req_addr = 12'h005;
    req_data = 48'h0000_0000_AAAA;
    cyc();
    check("pre_rst_we", we, 1'b1);
    check("pre_rst_addr", dst_addr, 4'h5);
    req_vld = '0;
    #1 rst = 1'b1;
    #1;
    check("async_rst_we", we, 1'b0);
    check("async_rst_addr", dst_addr, 4'h0);
    check("async_rst_dst", dst, 16'h0);
    check("async_rst_pend", pend, 16'h0);
    m_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    req_vld = 3'b111;
    req_addr = 12'h321;
    #2;
    check("post_rst_first", req_rdy, 3'b001);
    cyc();
    do_reset();
    req_vld = 3'b010;
    req_addr = 12'h000;
    req_data = 48'h0000_BEEF_0000;
    #2;
    check("r0_rdy", req_rdy, 3'b010);
    cyc();
    req_vld = '0;
    check("r0_we", we, 1'b0);
    check("r0_pend", pend, 16'h0);
    cyc();
    do_reset();
    req_vld = 3'b100;
    req_addr = 12'h700;
    req_data = 48'h1234_0000_0000;
    cyc();
    req_vld = '0;
    check("lat_we", we, 1'b1);
    check("lat_addr", dst_addr, 4'h7);
    check("lat_dst", dst, 16'h1234);
    check("lat_pend", pend, 16'h0080);
    cyc();
    check("lat_file", rf[7], 16'h1234);
    do_reset();
    req_vld = 3'b011;
    req_addr = 12'h044;
    req_data = 48'h0000_0002_0001;
    #2;
    check("same_first", req_rdy, 3'b001);
    cyc();
    req_vld = 3'b010;
    #2;
    check("same_second", req_rdy, 3'b010);
    cyc();
    req_vld = '0;
    cyc();
    check("same_file", rf[4], 16'h0002);
    for (int t = 0; t < 400; t++) begin
      req_vld = N'($urandom);
      req_addr = (N*4)'($urandom);
      req_data = (N*16)'({$urandom, $urandom});
      hold = ($urandom_range(0, 4) == 0);
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_wb_arb.md
# rf_wb_arb

Write-back arbiter for the 16×16 triple-ported register file. Shares the file's single write port (`we`/`dst_addr`/`dst`) among `NREQ` execution units (ALU, load, multiply, …) using a valid/ready handshake and round-robin grant. It registers the winning write so the file's negedge write sees stable data. It also exports a pending-write mask that decode uses for hazard checks.

## Interface
- `NREQ`, default 3: number of write-back requesters; legal range 2..8.
- `clk`, input, 1: clock. All state updates on posedge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `req_vld`, input, NREQ: requester i has a write pending.
- `req_addr`, input, NREQ×4: destination register per requester (packed, i at [4i+3:4i]).
- `req_data`, input, NREQ×16: write data per requester (packed).
- `req_rdy`, output, NREQ: grant. A transfer occurs on a posedge where `req_vld[i] & req_rdy[i]`.
- `hold`, input, 1: pipeline halt. Freezes the arbiter and suppresses writes.
- `we`, output, 1: register-file write enable (registered).
- `dst_addr`, output, 4: register-file write address (registered).
- `dst`, output, 16: register-file write data (registered).
- `pend`, output, 16: one-hot of `dst_addr` while `we` is high, else 0.

## Operation
- **Grant is combinational.** At most one bit of `req_rdy` is high, and only to a requester with `req_vld` high. `req_rdy` is all-zero when `hold`=1.
- **Priority (round-robin).** A pointer `last` holds the index of the last granted requester. The search starts at `(last+1) mod NREQ` and wraps. `last` updates only on a completed transfer.
- **Output stage.** On a transfer from requester g:
  - `dst_addr` ← `req_addr[g]`, `dst` ← `req_data[g]`.
  - `we` ← 1, except `we` ← 0 when `req_addr[g]`==0.
- **Writes to R0.** R0 is hardwired zero. A write to R0 is still granted and consumed (the requester is not stalled), but it never reaches the file.
- **No transfer.** In a cycle with no transfer and `hold`=0, `we` ← 0. `dst_addr` and `dst` keep their previous value.
- **`hold`=1.**
  - `we` output is forced to 0 combinationally.
  - The output registers and `last` hold their values.
  - No grants are issued.
  - When `hold` falls, a write that was latched before the hold but not yet committed is replayed: `we` returns to its stored value for exactly one cycle.
- **Same-address requests.** Two requesters targeting the same register in the same cycle are serialized by priority. Requester order across cycles is what sets the final value; the arbiter performs no merging.
- **Requester contract.** A requester must keep `req_addr`/`req_data` stable while `req_vld`=1 and not yet granted. The arbiter does not check this.

## Timing
- **Reset values:** `we`=0, `dst_addr`=0, `dst`=0, `pend`=0, `last`=NREQ-1 (so requester 0 wins first). `req_rdy` follows its combinational rule.
- **Latency.** A transfer at posedge N drives `we`/`dst_addr`/`dst` during cycle N→N+1. The file writes at the negedge inside that cycle. The value is readable from the file's ports in cycle N+1 (same-cycle reads are covered by the file's own bypass).
- **Throughput:** one write per cycle when `hold`=0.
- **Asynchronous reset mid-operation:** an in-flight output-stage write is discarded (`we`→0 immediately) and `last` is reinitialised.
- **`pend`** is combinational from the output registers and `we`. It is valid in the same cycle as `we`.

## Configuration
- `RF_WB_RR_EN` defined: round-robin priority as described above.
- `RF_WB_RR_EN` undefined:
  - Fixed priority; the lowest index always wins.
  - The `last` register is not built.
  - Starvation of higher-index requesters is accepted.

## Structure
- **Shared package `rf_pkg`:**
  - `RF_ADDR_W`=4, `RF_DATA_W`=16, `RF_NREGS`=16, `RF_ZERO_REG`=4'h0.
  - `typedef logic [RF_ADDR_W-1:0] rf_addr_t`, `typedef logic [RF_DATA_W-1:0] rf_data_t`.
- **Sub-module `rr_pick`:** purely combinational.
  - Inputs: request vector and start index.
  - Outputs: one-hot grant and the encoded winning index.
  - The fixed-priority build instantiates it with start index 0.

## Test plan
- **Reset.** Assert `rst` mid-write (`we`=1, `dst_addr`=5) → `we`, `dst_addr`, `dst` and `pend` all go to 0 immediately. After release, with all three requesters valid, requester 0 wins first.
- **Round-robin.** Hold `req_vld`=3'b111 for 6 cycles → grant order 0,1,2,0,1,2, with one `we` pulse per cycle. With the macro undefined → requester 0 is granted every cycle.
- **R0 drop.** Requester 1 writes addr 0, data 16'hBEEF → `req_rdy[1]` is high for one cycle, `we` stays 0, `pend`=0.
- **Latency/pend.** Requester 2 writes R7=16'h1234 at posedge N → during N→N+1, `we`=1, `dst_addr`=7, `dst`=16'h1234, `pend`=16'h0080. The file holds 16'h1234 at R7 in cycle N+1.
- **Hold.** Assert `hold` for 3 cycles with all requesters valid, right after a grant to R3 → `req_rdy`=0 and `we`=0 throughout. Drop `hold` → the R3 write appears for one cycle, then granting resumes from the next requester in round-robin order.
- **Same address.** Requesters 0 and 1 both target R4 in the same cycle with 16'h0001 and 16'h0002 → two consecutive writes, and R4 ends at the later-granted value (16'h0002 from reset state).
